// File: rtl/scp_pkg.sv
// Shared alert-level encodings for the scp_079 containment path.
// Level enum plus the one-hot {green,yellow,red} constants scp_079 consumes.
package scp_pkg;

    typedef enum logic [1:0] {
        LVL_GREEN    = 2'd0,
        LVL_YELLOW   = 2'd1,
        LVL_RED      = 2'd2,
        LVL_LOCKDOWN = 2'd3
    } level_e;

    // Bit order is {green, yellow, red}.
    localparam logic [2:0] ONEHOT_GREEN  = 3'b100;
    localparam logic [2:0] ONEHOT_YELLOW = 3'b010;
    localparam logic [2:0] ONEHOT_RED    = 3'b001;

    // LOCKDOWN shows as red on the one-hot lines.
    function automatic logic [2:0] level_onehot(level_e lvl);
        logic [2:0] oh;
        case (lvl)
            LVL_GREEN:  oh = ONEHOT_GREEN;
            LVL_YELLOW: oh = ONEHOT_YELLOW;
            default:    oh = ONEHOT_RED;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/threat_score.sv
// Saturating threat score with idle-time decay.
// Ports: clock, reset, threat_in, threat_wt[1:0], clear_in -> score.
module threat_score
    import scp_pkg::*;
#(
    parameter int SCORE_W   = 4,
    parameter int DECAY_CYC = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               threat_in,
    input  logic [1:0]         threat_wt,
    input  logic               clear_in,
    output logic [SCORE_W-1:0] score
);

    localparam int DW = $clog2(DECAY_CYC + 1);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [DW-1:0]      decay_q, decay_d;
    logic [SCORE_W:0]   sum;

    always_comb begin
        // One extra bit so the add can be clamped instead of wrapping.
        sum     = {1'b0, score_q} + (SCORE_W+1)'(threat_wt);
        score_d = score_q;
        decay_d = decay_q;
        if (clear_in) begin
            score_d = '0;
            decay_d = '0;
        end else if (threat_in) begin
            score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            decay_d = '0;
        end else if (decay_q == DW'(DECAY_CYC - 1)) begin
            if (score_q != '0) begin
                score_d = score_q - SCORE_W'(1);
            end
            decay_d = '0;
        end else begin
            decay_d = decay_q + DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            score_q <= '0;
            decay_q <= '0;
        end else begin
            score_q <= score_d;
            decay_q <= decay_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/alert_level_ctrl.sv
// Alert level controller: threat score to one-hot alert level with lockdown.
// Ports: clock, reset, threat_in, threat_wt, lockdown_in, clear_in ->
//        green, yellow, red, lockdown, level[1:0], score.
module alert_level_ctrl
    import scp_pkg::*;
#(
    parameter int SCORE_W   = 4,
    parameter int YELLOW_TH = 4,
    parameter int RED_TH    = 10,
    parameter int DECAY_CYC = 5,
    parameter int HOLD_CYC  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               threat_in,
    input  logic [1:0]         threat_wt,
    input  logic               lockdown_in,
    input  logic               clear_in,
    output logic               green,
    output logic               yellow,
    output logic               red,
    output logic               lockdown,
    output logic [1:0]         level,
    output logic [SCORE_W-1:0] score
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    logic [SCORE_W-1:0] score_w;
    level_e             state_q, state_d, target;
    logic [HW-1:0]      hold_q, hold_d;
    logic               green_q, yellow_q, red_q, lock_q;

    threat_score #(
        .SCORE_W  (SCORE_W),
        .DECAY_CYC(DECAY_CYC)
    ) u_score (
        .clock    (clock),
        .reset    (reset),
        .threat_in(threat_in),
        .threat_wt(threat_wt),
        .clear_in (clear_in),
        .score    (score_w)
    );

    always_comb begin
        if (score_w >= SCORE_W'(RED_TH)) begin
            target = LVL_RED;
        end else if (score_w >= SCORE_W'(YELLOW_TH)) begin
            target = LVL_YELLOW;
        end else begin
            target = LVL_GREEN;
        end
    end

    // Escalate at once; de-escalate one level per full hold period.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        if (state_q == LVL_LOCKDOWN) begin
            if (clear_in && !lockdown_in) begin
                state_d = LVL_GREEN;
            end
        end else if (lockdown_in) begin
            state_d = LVL_LOCKDOWN;
        end else if (target > state_q) begin
            state_d = target;
        end else if (target < state_q) begin
            if (hold_q == HW'(HOLD_CYC - 1)) begin
                state_d = level_e'(state_q - 2'd1);
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= LVL_GREEN;
            hold_q   <= '0;
            green_q  <= 1'b1;
            yellow_q <= 1'b0;
            red_q    <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            {green_q, yellow_q, red_q} <= level_onehot(state_d);
            lock_q  <= (state_d == LVL_LOCKDOWN);
        end
    end

    assign green    = green_q;
    assign yellow   = yellow_q;
    assign red      = red_q;
    assign lockdown = lock_q;
    assign level    = state_q;
    assign score    = score_w;

endmodule

// File: tb/tb_alert_level_ctrl.sv
// Bench for alert_level_ctrl: directed plan plus random traffic.
// Outputs checked every cycle against a behavioural model.
module tb_alert_level_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       threat_in = 1'b0;
    logic [1:0] threat_wt = 2'd0;
    logic       lockdown_in = 1'b0;
    logic       clear_in = 1'b0;
    logic       green, yellow, red, lockdown;
    logic [1:0] level;
    logic [3:0] score;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // Behavioural model state
    int m_lvl = 0;
    int m_score = 0;
    int m_idle = 0;
    int m_hold = 0;

    alert_level_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .threat_in  (threat_in),
        .threat_wt  (threat_wt),
        .lockdown_in(lockdown_in),
        .clear_in   (clear_in),
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .lockdown   (lockdown),
        .level      (level),
        .score      (score)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: level from thresholds, immediate rise, slow fall.
    always @(posedge clock) begin
        int tgt;
        if (reset) begin
            m_lvl = 0;
            m_score = 0;
            m_idle = 0;
            m_hold = 0;
        end else begin
            tgt = (m_score >= 10) ? 2 : (m_score >= 4) ? 1 : 0;
            if (m_lvl == 3) begin
                m_hold = 0;
                if (clear_in && !lockdown_in) m_lvl = 0;
            end else if (lockdown_in) begin
                m_lvl = 3;
                m_hold = 0;
            end else if (tgt > m_lvl) begin
                m_lvl = tgt;
                m_hold = 0;
            end else if (tgt < m_lvl) begin
                m_hold++;
                if (m_hold == 8) begin
                    m_lvl--;
                    m_hold = 0;
                end
            end else begin
                m_hold = 0;
            end
            if (clear_in) begin
                m_score = 0;
                m_idle = 0;
            end else if (threat_in) begin
                m_score += int'(threat_wt);
                if (m_score > 15) m_score = 15;
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == 5) begin
                    m_idle = 0;
                    if (m_score > 0) m_score--;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            chk("green", int'(green), int'(m_lvl == 0));
            chk("yellow", int'(yellow), int'(m_lvl == 1));
            chk("red", int'(red), int'(m_lvl >= 2));
            chk("lockdown", int'(lockdown), int'(m_lvl == 3));
            chk("level", int'(level), m_lvl);
            chk("score", int'(score), m_score);
            chk("onehot", int'(green) + int'(yellow) + int'(red), 1);
        end
    end

    task automatic cyc(bit rst, bit thr, int wt, bit lk, bit clr);
        reset = rst;
        threat_in = thr;
        threat_wt = 2'(wt);
        lockdown_in = lk;
        clear_in = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wait_score(int want, int maxc);
        int n = 0;
        while (int'(score) != want && n < maxc) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk("wait_score", int'(score), want);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0);
        checking = 1'b1;
        cyc(1, 0, 0, 0, 0);
        chk("rst_green", int'(green), 1);
        chk("rst_red", int'(red), 0);
        chk("rst_lock", int'(lockdown), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_score", int'(score), 0);

        // Escalation: 3,6,9,12
        cyc(0, 1, 3, 0, 0);
        chk("esc_s3", int'(score), 3);
        cyc(0, 1, 3, 0, 0);
        chk("esc_s6", int'(score), 6);
        chk("esc_l0", int'(level), 0);
        cyc(0, 1, 3, 0, 0);
        chk("esc_s9", int'(score), 9);
        chk("esc_yel", int'(yellow), 1);
        cyc(0, 1, 3, 0, 0);
        chk("esc_s12", int'(score), 12);
        chk("esc_l1", int'(level), 1);
        idle(1);
        chk("esc_red", int'(red), 1);
        chk("mdl_s12", m_score, 12);

        // Decay 12 -> 9, then yellow after 8 more cycles
        idle(4);
        chk("decay_11", int'(score), 11);
        wait_score(9, 20);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            chk("hold_red", int'(level), 2);
        end
        idle(1);
        chk("drop_yel", int'(level), 1);
        chk("mdl_yel", m_lvl, 1);
        wait_score(3, 60);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            chk("hold_yel", int'(level), 1);
        end
        idle(1);
        chk("drop_grn", int'(level), 0);

        // Saturation and zero-weight threat
        for (int i = 0; i < 10; i++) cyc(0, 1, 3, 0, 0);
        chk("sat15", int'(score), 15);
        idle(2);
        cyc(0, 1, 0, 0, 0);
        chk("wt0_15", int'(score), 15);
        idle(4);
        chk("wt0_hold", int'(score), 15);
        idle(1);
        chk("wt0_dec", int'(score), 14);
        chk("mdl_s14", m_score, 14);

        // Reset while red at 12
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 3, 0, 0);
        chk("pre_rst12", int'(score), 12);
        chk("pre_rst_red", int'(red), 1);
        cyc(1, 0, 0, 0, 0);
        chk("mid_rst_grn", int'(green), 1);
        chk("mid_rst_s0", int'(score), 0);
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 2, 0, 0);
        idle(4);
        chk("rst_dec_5", int'(score), 5);
        idle(1);
        chk("rst_dec_4", int'(score), 4);

        // Lockdown from yellow
        chk("pre_lk_yel", int'(yellow), 1);
        cyc(0, 0, 0, 1, 0);
        chk("lk_lock", int'(lockdown), 1);
        chk("lk_red", int'(red), 1);
        chk("lk_level", int'(level), 3);
        idle(40);
        chk("lk_hold", int'(level), 3);
        cyc(0, 0, 0, 1, 1);
        chk("lk_both", int'(level), 3);
        cyc(0, 1, 3, 0, 1);
        chk("lk_clr_g", int'(green), 1);
        chk("lk_clr_s", int'(score), 0);
        chk("lk_clr_l", int'(lockdown), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 79) == 0,
                $urandom_range(0, 39) == 0);
        end

        checking = 1'b0;
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alert_level_ctrl.md
Name: alert_level_ctrl

Overview:
- Upstream stage of the scp_079 containment FSM: turns raw threat events into the one-hot {green,yellow,red} alert inputs that scp_079 consumes.
- Keeps a saturating threat score that decays while no threats arrive. The score is mapped to an alert level with one rule: escalate immediately, de-escalate one step at a time after a hold period.
- Supports a latched manual lockdown, which forces red until it is explicitly cleared.
- The system clock is 1 Hz, so one cycle is one second of design time.

Parameters:
- SCORE_W, 4: threat score width; the score saturates at 2^SCORE_W-1.
- YELLOW_TH, 4: score at or above this value targets yellow.
- RED_TH, 10: score at or above this value targets red; must be greater than YELLOW_TH.
- DECAY_CYC, 5: number of consecutive threat-free cycles per score decrement.
- HOLD_CYC, 8: number of consecutive cycles the lower target must persist before dropping one level.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- threat_in  input  1  threat event valid, sampled each cycle
- threat_wt  input  2  weight added to the score when threat_in=1 (0..3)
- lockdown_in  input  1  manual lockdown request
- clear_in  input  1  operator clear
- green  output  1  alert level green (one-hot with yellow and red)
- yellow  output  1  alert level yellow
- red  output  1  alert level red
- lockdown  output  1  high while in LOCKDOWN
- level  output  2  encoded level: 0=GREEN, 1=YELLOW, 2=RED, 3=LOCKDOWN
- score  output  SCORE_W  current threat score

Behaviour:
- Reset (synchronous, highest priority):
  - score=0, decay_cnt=0, hold_cnt=0, state=GREEN.
  - Outputs: green=1, yellow=0, red=0, lockdown=0, level=0.
  - A reset asserted mid-operation, in any state including LOCKDOWN, takes effect at the next edge.
- Priority among inputs: reset > lockdown_in > clear_in > threat_in > decay.
- Score update, per cycle:
  - clear_in=1: score←0, decay_cnt←0.
  - Else if threat_in=1: score←min(score+threat_wt, 2^SCORE_W-1), decay_cnt←0. The addition is done at SCORE_W+1 bits and clamped, so the score never wraps. threat_wt=0 with threat_in=1 still resets decay_cnt.
  - Else if decay_cnt==DECAY_CYC-1: score←max(score-1, 0), decay_cnt←0.
  - Else: decay_cnt←decay_cnt+1.
- Target level is computed combinationally from the registered score: RED if score≥RED_TH, YELLOW if score≥YELLOW_TH, otherwise GREEN.
- FSM states: GREEN, YELLOW, RED, LOCKDOWN.
  - Any non-LOCKDOWN state with lockdown_in=1: go to LOCKDOWN next edge, hold_cnt←0.
  - target>state: go to target next edge. GREEN→RED is allowed directly. hold_cnt←0.
  - target<state: hold_cnt increments. When hold_cnt==HOLD_CYC-1, drop exactly one level and set hold_cnt←0.
  - target==state: hold_cnt←0.
  - LOCKDOWN: ignores target, threat_in and decay for state purposes; the score still updates. Exits only on clear_in=1 (with lockdown_in=0), going to GREEN with score←0 on the same edge. If lockdown_in and clear_in are both 1, the block stays in LOCKDOWN.
  - clear_in outside LOCKDOWN only zeroes the score; the level then de-escalates through the normal hold path.
- Outputs are registered decodes of state.
  - LOCKDOWN drives red=1 and lockdown=1.
  - Exactly one of green/yellow/red is high at all times after reset.
- Latency: threat sampled at edge N → score visible after edge N → level change visible after edge N+1 (2 cycles). lockdown_in → lockdown=1 in 1 cycle.

Decomposition:
- Shared package scp_pkg holds:
  - Level encodings LVL_GREEN=0, LVL_YELLOW=1, LVL_RED=2, LVL_LOCKDOWN=3.
  - The one-hot {green,yellow,red} constants shared with scp_079.
- One sub-module, threat_score: holds the saturating score and the decay counter (threat_in, threat_wt, clear_in → score). The alert FSM stays in the top module.

Test Plan:
- Reset for 2 cycles, all other inputs 0 → green=1, yellow=red=lockdown=0, level=0, score=0.
- threat_in=1, threat_wt=3 for 4 cycles from GREEN → score 3,6,9,12. Yellow one cycle after score=6; red one cycle after score=12.
- From red with score=12, hold inputs 0 → score drops 1 every 5 cycles. After score=9 and 8 further cycles → yellow, never skipping a level. After score<4 and 8 further cycles → green.
- threat_in=1, threat_wt=3 for 10 cycles → score saturates at 15 and holds, no wrap. One cycle with threat_in=1, threat_wt=0 → score stays 15 and decay_cnt resets.
- lockdown_in pulse while yellow → next cycle lockdown=1, red=1, level=3. 40 cycles of no threats keep LOCKDOWN. clear_in with lockdown_in=1 keeps LOCKDOWN. clear_in alone → green=1 and score=0 next cycle.
- reset asserted while red with score=12 → next edge green=1, score=0, and decay restarts from 0.
